imem_loader: RTL and testbench

- Boot-time writer for the instruction memory.
- Accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words from it.
- Writes those words into instruction memory through a dedicated write port while holding the core in reset.
- Releases the core only after the frame checksum verifies.

---
 rtl/imem_loader.sv | 151 +++++++++++++++
 tb/tb_imem_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: parses a length/payload/checksum byte frame,
// writes little-endian words through a registered write port, and releases the core on success.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wd,
  output logic        core_hold,
  output logic        done,
  output logic        error
);

  localparam int          WIDX_W    = $clog2(MAX_WORDS + 1);
  localparam logic [31:0] MAX_WORDS_U = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [WIDX_W-1:0]   word_idx_q, word_idx_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [23:0]         buf_q, buf_d;
  logic [7:0]          chk_q, chk_d;
  logic                we_q, we_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wd_q, wd_d;
  logic                hold_q, hold_d;

  logic                accept;
  logic [15:0]         len_full;

  assign in_ready  = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                     (state_q == S_DATA) || (state_q == S_CHK);
  assign accept    = in_valid && in_ready;
  assign len_full  = {in_data, len_q[7:0]};

  assign imem_we   = we_q;
  assign imem_addr = addr_q;
  assign imem_wd   = wd_q;
  assign core_hold = hold_q;
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERR);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    buf_d      = buf_q;
    chk_d      = chk_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wd_d       = wd_q;
    hold_d     = hold_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN0;
          len_d      = '0;
          word_idx_d = '0;
          byte_idx_d = '0;
          chk_d      = '0;
          hold_d     = 1'b1;
        end
      end
      S_LEN0: begin
        if (accept) begin
          len_d[7:0] = in_data;
          chk_d      = chk_q ^ in_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d = len_full;
          chk_d = chk_q ^ in_data;
          if (32'(len_full) > MAX_WORDS_U) state_d = S_ERR;
          else if (len_full == 16'd0)      state_d = S_CHK;
          else                             state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          chk_d      = chk_q ^ in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // The strobe is registered, so the CHK byte can follow the last payload byte at full rate.
            we_d       = 1'b1;
            addr_d     = BASE_ADDR + (32'(word_idx_q) << 2);
            wd_d       = {in_data, buf_q};
            word_idx_d = word_idx_q + 1'b1;
            if ((32'(word_idx_q) + 32'd1) == 32'(len_q)) state_d = S_CHK;
          end else begin
            buf_d[{byte_idx_q, 3'b000} +: 8] = in_data;
          end
        end
      end
      S_CHK: begin
        if (accept) begin
          if (in_data == chk_q) begin
            state_d = S_DONE;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      buf_q      <= '0;
      chk_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= BASE_ADDR;
      wd_q       <= '0;
      hold_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      buf_q      <= buf_d;
      chk_q      <= chk_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      hold_q     <= hold_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of whole frames plus hand-written
// sequences for reset, length boundary and reload from DONE.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;

  logic        in_ready0, imem_we0, core_hold0, done0, error0;
  logic [31:0] imem_addr0, imem_wd0;
  logic        in_ready1, imem_we1, core_hold1, done1, error1;
  logic [31:0] imem_addr1, imem_wd1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] wr0_q[$];
  logic [63:0] wr1_q[$];

  always #5 clk = ~clk;

  imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256)) dut0 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .imem_we(imem_we0), .imem_addr(imem_addr0), .imem_wd(imem_wd0),
    .core_hold(core_hold0), .done(done0), .error(error0)
  );

  imem_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(256)) dut1 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .imem_we(imem_we1), .imem_addr(imem_addr1), .imem_wd(imem_wd1),
    .core_hold(core_hold1), .done(done1), .error(error1)
  );

  always @(negedge clk) begin
    if (imem_we0) wr0_q.push_back({imem_addr0, imem_wd0});
    if (imem_we1) wr1_q.push_back({imem_addr1, imem_wd1});
  end

  typedef struct packed {
    logic [95:0] stream;   // first byte in bits [95:88]
    logic [3:0]  nbytes;
    logic        throttle;
    logic [1:0]  nwr;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic        done;
    logic        error;
  } vec_t;

  localparam logic [95:0] NOMINAL = {8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
                                     8'h93, 8'h05, 8'h15, 8'h00, 8'h37, 8'h00};

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit throttle, output int waits);
    bit acc;
    waits = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      in_data  = b;
      in_valid = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      acc      = in_valid && in_ready0;
      @(posedge clk);
      if (acc) return;
      waits++;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL send_byte timeout: byte %h not accepted within 400 cycles", b);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag, input bit issue_start);
    int w;
    int waits_total;
    waits_total = 0;
    wr0_q.delete();
    wr1_q.delete();
    if (issue_start) do_start();
    for (int k = 0; k < int'(v.nbytes); k++) begin
      send_byte(v.stream[95 - 8*k -: 8], v.throttle, w);
      waits_total += w;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, ".done"},      32'(done0),      32'(v.done));
    check({tag, ".error"},     32'(error0),     32'(v.error));
    check({tag, ".core_hold"}, 32'(core_hold0), 32'(!v.done));
    check({tag, ".in_ready"},  32'(in_ready0),  32'd0);
    if (!v.throttle) check({tag, ".stall_cycles"}, 32'(waits_total), 32'd0);
    repeat (2) @(negedge clk);
    check({tag, ".num_writes"}, 32'(wr0_q.size()), 32'(v.nwr));
    for (int j = 0; j < int'(v.nwr) && j < wr0_q.size(); j++) begin
      check($sformatf("%s.w%0d.addr", tag, j), wr0_q[j][63:32], 32'(4*j));
      check($sformatf("%s.w%0d.data", tag, j), wr0_q[j][31:0], (j == 0) ? v.wd0 : v.wd1);
    end
    if (v.nwr != 2'd0) begin
      check({tag, ".addr_hold"}, imem_addr0, 32'(4*(int'(v.nwr) - 1)));
      check({tag, ".wd_hold"},   imem_wd0,   (v.nwr == 2'd1) ? v.wd0 : v.wd1);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".in_ready"},  32'(in_ready0),  32'd0);
    check({tag, ".imem_we"},   32'(imem_we0),   32'd0);
    check({tag, ".imem_addr"}, imem_addr0,      32'h0);
    check({tag, ".imem_wd"},   imem_wd0,        32'h0);
    check({tag, ".core_hold"}, 32'(core_hold0), 32'd1);
    check({tag, ".done"},      32'(done0),      32'd0);
    check({tag, ".error"},     32'(error0),     32'd0);
    check({tag, ".addr1"},     imem_addr1,      32'h100);
  endtask

  initial begin
    int w;

    vecs[0] = '{stream: NOMINAL, nbytes: 4'd11, throttle: 1'b0, nwr: 2'd2,
                wd0: 32'h00A00513, wd1: 32'h00150593, done: 1'b1, error: 1'b0};
    vecs[1] = '{stream: {NOMINAL[95:16], 8'h36, 8'h00}, nbytes: 4'd11, throttle: 1'b0, nwr: 2'd2,
                wd0: 32'h00A00513, wd1: 32'h00150593, done: 1'b0, error: 1'b1};
    vecs[2] = '{stream: {8'h01, 8'h01, 80'h0}, nbytes: 4'd2, throttle: 1'b0, nwr: 2'd0,
                wd0: 32'h0, wd1: 32'h0, done: 1'b0, error: 1'b1};
    vecs[3] = '{stream: {8'h00, 8'h00, 8'h00, 72'h0}, nbytes: 4'd3, throttle: 1'b0, nwr: 2'd0,
                wd0: 32'h0, wd1: 32'h0, done: 1'b1, error: 1'b0};
    vecs[4] = '{stream: {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h23, 40'h0}, nbytes: 4'd7,
                throttle: 1'b0, nwr: 2'd1, wd0: 32'hDEADBEEF, wd1: 32'h0, done: 1'b1, error: 1'b0};
    vecs[5] = '{stream: NOMINAL, nbytes: 4'd11, throttle: 1'b1, nwr: 2'd2,
                wd0: 32'h00A00513, wd1: 32'h00150593, done: 1'b1, error: 1'b0};

    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    reset = 1'b1;
    @(negedge clk);
    check("idle.in_ready", 32'(in_ready0), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i), 1'b1);

    // N == MAX_WORDS is legal: loader must sit in DATA, not ERR.
    do_start();
    send_byte(8'h00, 1'b0, w);
    send_byte(8'h01, 1'b0, w);
    @(negedge clk);
    in_valid = 1'b0;
    check("max_len.error",    32'(error0),    32'd0);
    check("max_len.in_ready", 32'(in_ready0), 32'd1);

    // Mid-load reset after five payload bytes, asserted away from any clock edge.
    reset = 1'b0;
    #1;
    check_reset_values("rst_maxlen");
    @(negedge clk);
    reset = 1'b1;
    do_start();
    for (int k = 0; k < 7; k++) send_byte(NOMINAL[95 - 8*k -: 8], 1'b0, w);
    @(negedge clk);
    in_valid = 1'b0;
    check("midrst.pre_wd", imem_wd0, 32'h00A00513);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    reset = 1'b1;
    run_vec(vecs[0], "after_rst", 1'b1);

    // Reload from DONE: hold must rise in the same cycle DONE is left.
    wr1_q.delete();
    @(negedge clk);
    check("reload.pre_hold", 32'(core_hold0), 32'd0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("reload.hold0", 32'(core_hold0), 32'd1);
    check("reload.done0", 32'(done0),      32'd0);
    check("reload.hold1", 32'(core_hold1), 32'd1);
    check("reload.rdy1",  32'(in_ready1),  32'd1);
    run_vec(vecs[0], "reload", 1'b0);
    check("reload.dut1.done",  32'(done1),  32'd1);
    check("reload.dut1.error", 32'(error1), 32'd0);
    check("reload.dut1.nwr",   32'(wr1_q.size()), 32'd2);
    if (wr1_q.size() == 2) begin
      check("reload.dut1.w0.addr", wr1_q[0][63:32], 32'h100);
      check("reload.dut1.w0.data", wr1_q[0][31:0],  32'h00A00513);
      check("reload.dut1.w1.addr", wr1_q[1][63:32], 32'h104);
      check("reload.dut1.w1.data", wr1_q[1][31:0],  32'h00150593);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
